// File: rtl/seven_segment_driver_if.sv
// Signal bundle between a display data source and the seven-segment scan driver.
//   display_val[31:0] : eight hex nibbles, digit 0 in [3:0] (rightmost digit)
//   dp_val[7:0]       : per-digit decimal point request, 1 = lit
//   digit_en[7:0]     : per-digit enable, 0 = digit blanked
//   segments[6:0]     : active-low segments, [6]=A .. [0]=G
//   dp                : active-low decimal point
//   anode[7:0]        : active-low digit selects, at most one low
//   frame_start       : one-cycle pulse when digit 0 becomes selected
interface seven_segment_driver_if;
  logic [31:0] display_val;
  logic [7:0]  dp_val;
  logic [7:0]  digit_en;
  logic [6:0]  segments;
  logic        dp;
  logic [7:0]  anode;
  logic        frame_start;

  modport master (
    output display_val, dp_val, digit_en,
    input  segments, dp, anode, frame_start
  );

  modport slave (
    input  display_val, dp_val, digit_en,
    output segments, dp, anode, frame_start
  );
endinterface

// File: rtl/seven_segment_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Digits are scanned 0..7, one anode low at a time, each for DWELL clocks.
// Inputs are captured into shadow registers only at frame boundaries so a
// frame never shows a mix of old and new values.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : seven_segment_driver_if.slave (data inputs, display outputs)
module seven_segment_driver #(
  parameter int unsigned CLK_FREQUENCY          = 100_000_000,
  parameter int unsigned MIN_SEGMENT_DISPLAY_US = 10_000
) (
  input  logic                         clk,
  input  logic                         rst,
  seven_segment_driver_if.slave        bus
);

  localparam int unsigned DWELL = CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
  localparam int unsigned CW    = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  if (DWELL < 2) begin : g_dwell_check
    $error("seven_segment_driver: DWELL must be at least 2 clocks");
  end

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    idx_q,    idx_d;
  logic [31:0]   sh_val_q, sh_val_d;
  logic [7:0]    sh_dp_q,  sh_dp_d;
  logic [7:0]    sh_en_q,  sh_en_d;
  logic [7:0]    anode_q,  anode_d;
  logic [6:0]    seg_q,    seg_d;
  logic          dp_q,     dp_d;
  logic          fs_q,     fs_d;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    fs_d     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d  = SCAN;
        cnt_d    = '0;
        idx_d    = '0;
        sh_val_d = bus.display_val;
        sh_dp_d  = bus.dp_val;
        sh_en_d  = bus.digit_en;
        fs_d     = 1'b1;
      end
      default: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            sh_val_d = bus.display_val;
            sh_dp_d  = bus.dp_val;
            sh_en_d  = bus.digit_en;
            fs_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Drive is derived from next-state index and shadows, so the outputs of
    // a new slot (including a freshly reloaded frame) appear on the same edge
    // the index changes; within a slot these terms are constant.
    if (sh_en_d[idx_d]) begin
      anode_d = ~(8'h01 << idx_d);
      seg_d   = encode(sh_val_d[{idx_d, 2'b00} +: 4]);
      dp_d    = ~sh_dp_d[idx_d];
    end else begin
      anode_d = '1;
      seg_d   = '1;
      dp_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      anode_q  <= '1;
      seg_q    <= '1;
      dp_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      sh_en_q  <= sh_en_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.anode       = anode_q;
  assign bus.segments    = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_driver.sv
module tb_seven_segment_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [6:0] seg_tbl [16];

  seven_segment_driver_if bus();

  seven_segment_driver #(
    .CLK_FREQUENCY(1_000_000),
    .MIN_SEGMENT_DISPLAY_US(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reset, load inputs, release; returns 1 time unit after the first scan edge
  // (slot 0, cycle 0 of the first frame).
  task automatic start_scan(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    bus.display_val = v;
    bus.dp_val      = d;
    bus.digit_en    = e;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset;
    bus.display_val = 32'h0123_4567;
    bus.dp_val      = 8'h00;
    bus.digit_en    = 8'hFF;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.anode !== 8'hFF || bus.segments !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: anode=%h seg=%h dp=%b fs=%b, required FF 7F 1 0",
               bus.anode, bus.segments, bus.dp, bus.frame_start);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.anode !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_release_no_edge: anode=%h, required FF", bus.anode);
    end
    step();
    n_checks++;
    if (bus.anode !== 8'hFE || bus.frame_start !== 1'b1 || bus.segments !== 7'b0001111) begin
      n_fail++;
      $display("FAIL reset_first_edge: anode=%h fs=%b seg=%b, required FE 1 0001111",
               bus.anode, bus.frame_start, bus.segments);
    end
  endtask

  task automatic test_scan_order;
    logic [7:0] exp_an;
    logic       exp_fs;
    start_scan(32'h0123_4567, 8'h00, 8'hFF);
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < 8; c++) begin
        exp_an = ~(8'h01 << (s % 8));
        exp_fs = (c == 0) && (s % 8 == 0);
        n_checks++;
        if (bus.anode !== exp_an || bus.frame_start !== exp_fs) begin
          n_fail++;
          $display("FAIL scan_order slot %0d cycle %0d: anode=%h fs=%b, required %h %b",
                   s, c, bus.anode, bus.frame_start, exp_an, exp_fs);
        end
        step();
      end
    end
  endtask

  task automatic test_frame_spacing;
    int cnt;
    start_scan(32'h0000_0000, 8'h00, 8'hFF);
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (bus.frame_start !== 1'b1 && cnt < 200);
      n_checks++;
      if (cnt != 64) begin
        n_fail++;
        $display("FAIL frame_spacing %0d: gap=%0d cycles, required 64", f, cnt);
      end
    end
  endtask

  task automatic test_encoding;
    logic [31:0] vals [2];
    logic [31:0] v;
    logic [3:0]  nib;
    vals[0] = 32'h0123_4567;
    vals[1] = 32'h89AB_CDEF;
    for (int k = 0; k < 2; k++) begin
      v = vals[k];
      start_scan(v, 8'h00, 8'hFF);
      for (int s = 0; s < 8; s++) begin
        nib = v[4*s +: 4];
        n_checks++;
        if (bus.segments !== seg_tbl[nib] || bus.dp !== 1'b1 || bus.anode !== ~(8'h01 << s)) begin
          n_fail++;
          $display("FAIL encoding %h slot %0d: seg=%b dp=%b anode=%h, required %b 1 %h",
                   v, s, bus.segments, bus.dp, bus.anode, seg_tbl[nib], ~(8'h01 << s));
        end
        repeat (8) step();
      end
    end
  endtask

  task automatic test_dp;
    logic exp_dp;
    start_scan(32'h0000_0000, 8'b1000_0001, 8'hFF);
    for (int s = 0; s < 8; s++) begin
      exp_dp = (s == 0 || s == 7) ? 1'b0 : 1'b1;
      n_checks++;
      if (bus.dp !== exp_dp) begin
        n_fail++;
        $display("FAIL decimal_point slot %0d: dp=%b, required %b", s, bus.dp, exp_dp);
      end
      repeat (8) step();
    end
  endtask

  task automatic test_blanking;
    logic [31:0] v;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    v = 32'hFEDC_BA98;
    start_scan(v, 8'h00, 8'b1111_0000);
    for (int s = 0; s < 8; s++) begin
      if (s < 4) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(8'h01 << s);
        exp_seg = seg_tbl[v[4*s +: 4]];
      end
      n_checks++;
      if (bus.anode !== exp_an || bus.segments !== exp_seg || bus.frame_start !== (s == 0)) begin
        n_fail++;
        $display("FAIL blanking slot %0d: anode=%h seg=%b fs=%b, required %h %b %b",
                 s, bus.anode, bus.segments, bus.frame_start, exp_an, exp_seg, (s == 0));
      end
      repeat (8) step();
    end
    n_checks++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL blanking_frame_spacing: fs=%b after 64 cycles, required 1", bus.frame_start);
    end
  endtask

  task automatic test_no_tearing;
    start_scan(32'h1111_1111, 8'h00, 8'hFF);
    repeat (27) step();
    bus.display_val = 32'h2222_2222;
    step();
    n_checks++;
    if (bus.segments !== 7'b1001111 || bus.anode !== 8'hF7) begin
      n_fail++;
      $display("FAIL no_tearing slot 3: seg=%b anode=%h, required 1001111 F7", bus.segments, bus.anode);
    end
    repeat (4) step();
    for (int s = 4; s < 8; s++) begin
      n_checks++;
      if (bus.segments !== 7'b1001111) begin
        n_fail++;
        $display("FAIL no_tearing slot %0d: seg=%b, required 1001111", s, bus.segments);
      end
      repeat (8) step();
    end
    n_checks++;
    if (bus.frame_start !== 1'b1 || bus.anode !== 8'hFE || bus.segments !== 7'b0010010) begin
      n_fail++;
      $display("FAIL no_tearing next_frame: fs=%b anode=%h seg=%b, required 1 FE 0010010",
               bus.frame_start, bus.anode, bus.segments);
    end
  endtask

  task automatic test_reset_mid_scan;
    start_scan(32'h0123_4567, 8'hFF, 8'hFF);
    repeat (42) step();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.anode !== 8'hFF || bus.segments !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_scan async: anode=%h seg=%b dp=%b fs=%b, required FF 1111111 1 0",
               bus.anode, bus.segments, bus.dp, bus.frame_start);
    end
    bus.display_val = 32'h0000_0003;
    bus.dp_val      = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.anode !== 8'hFE || bus.frame_start !== 1'b1 || bus.segments !== 7'b0000110 || bus.dp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_scan restart: anode=%h fs=%b seg=%b dp=%b, required FE 1 0000110 0",
               bus.anode, bus.frame_start, bus.segments, bus.dp);
    end
  endtask

  initial begin
    seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    test_reset();
    test_scan_order();
    test_frame_spacing();
    test_encoding();
    test_dp();
    test_blanking();
    test_no_tearing();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
